vga_sync_rx: RTL and testbench
==============================

# vga_sync_rx

Receive-side counterpart of the VGA timing generator. Consumes the active-low h_sync/v_sync pair, locks onto the raster using the `defs_vga` timing constants, and reconstructs draw_active and the active pixel coordinates. It reports lock state and timing errors. It serves as an in-system monitor of the generator output and as the front end for any block that must follow an externally timed raster.

## Interface
Timing constants are imported from `defs_vga` (`VGA_H_ACTIVE/FRONT/SYNC/BACK`, `VGA_V_ACTIVE/FRONT/SYNC/BACK`).

Parameters:
- `ERR_CNT_W`, default 8, width of the saturating error counter.

Ports:
- `clk`: input, 1, pixel clock.
- `rst_n`: input, 1, reset, asynchronous, active-low.
- `i_h_sync`: input, 1, horizontal sync, low during the sync window.
- `i_v_sync`: input, 1, vertical sync, low during the sync window.
- `o_locked`: output, 1, raster locked.
- `o_draw_active`: output, 1, current sample lies in the active area.
- `o_active_x`: output, `$clog2(VGA_H_ACTIVE)`, pixel column, valid when `o_draw_active` is 1.
- `o_active_y`: output, `$clog2(VGA_V_ACTIVE)`, pixel row, valid when `o_draw_active` is 1.
- `o_frame_start`: output, 1, 1-cycle pulse for the sample at (0,0) while locked.
- `o_err`: output, 1, 1-cycle pulse on a timing violation while locked.
- `o_err_cnt`: output, `ERR_CNT_W`, count of errors, saturating.

## Operation
Derived constants:
- H_TOTAL = sum of the H terms; V_TOTAL = sum of the V terms.
- HS_START = H_ACTIVE+H_FRONT; HS_END = HS_START+H_SYNC.
- VS_START = V_ACTIVE+V_FRONT; VS_END = VS_START+V_SYNC.

Edge detection:
- Registers `h_prev` and `v_prev` hold the previous sample; both reset to 1.
- Falling edge = prev 1 and current 0. Rising edge = prev 0 and current 1.

Position counters:
- `x_cnt`/`y_cnt` hold the predicted position of the sample currently on the inputs.
- `x_cur` = HS_START on an h falling edge in SEARCH or H_ALIGNED; otherwise `x_cur` = `x_cnt`.
- Next `x_cnt` = `x_cur`+1, wrapping to 0 after H_TOTAL-1.
- `y_cnt` increments only when x wraps, wrapping to 0 after V_TOTAL-1.
- On the v falling edge that causes the H_ALIGNED→LOCKED transition, `y_cur` is loaded with VS_START.

State machine:
- SEARCH: an h falling edge moves to H_ALIGNED and aligns x. v activity is ignored.
- H_ALIGNED: an h falling edge with `x_cnt` != HS_START realigns x silently. A v falling edge with `x_cur`==0 moves to LOCKED and loads y. A v falling edge with `x_cur`!=0 stays in H_ALIGNED with no error.
- LOCKED errors:
  - h falling edge with `x_cnt` != HS_START.
  - `x_cnt`==HS_START with `i_h_sync`==1 (missing edge).
  - h rising edge with `x_cnt` != HS_END.
  - v falling edge with (`x_cnt`,`y_cnt`) != (0,VS_START).
  - v rising edge with (`x_cnt`,`y_cnt`) != (0,VS_END).
- Any error in LOCKED returns to SEARCH, pulses `o_err` once, and increments `o_err_cnt` once (saturating at all-ones). Several violations in the same cycle count as one error.
- If the offending event was an h falling edge, the same cycle also aligns x and the next state is H_ALIGNED instead of SEARCH.

Outputs:
- `o_draw_active` = LOCKED && `x_cur` < H_ACTIVE && `y_cur` < V_ACTIVE.
- `o_active_x`/`o_active_y` = `x_cur`/`y_cur` truncated when draw_active, otherwise 0.

## Timing
- All outputs are registered: each output reflects the input sample from one cycle earlier (1-cycle latency).
- Reset values: every output is 0, state is SEARCH, `x_cnt`/`y_cnt` are 0, `h_prev`/`v_prev` are 1.
- `o_locked` rises 1 cycle after the sample carrying the accepted v falling edge. It falls 1 cycle after the erroring sample, in the same cycle as the `o_err` pulse.
- When driven directly by the generator, the receiver's `o_draw_active`/`o_active_x`/`o_active_y` equal the generator's outputs delayed by exactly 1 cycle once locked.
- Reset asserted mid-frame clears everything immediately; lock is reacquired from scratch.

## Test plan
Bench configuration: `defs_vga` = 640x480 (H 640/16/96/48 = 800, V 480/10/2/33 = 525).

1. Generator connected, both released from reset together:
   - First h falling edge at cycle 656 → H_ALIGNED.
   - v falling edge at line 490, x=0 → `o_locked`=1.
   - Next frame: `o_frame_start` pulses once; x/y track the generator delayed 1 cycle; `o_err_cnt` stays 0 over 3 frames.
2. After lock, hold `i_h_sync` high for one line:
   - `o_err` pulses at the HS_START sample (+1 cycle).
   - `o_err_cnt`=1 and `o_locked`=0.
   - Relock occurs within 2 frames.
3. After lock, inject a 95-cycle h sync pulse (rising edge at x=751) → `o_err` pulse, state H_ALIGNED.
4. Shift v_sync falling edge to x=5 in LOCKED → error.
   - In H_ALIGNED, the same shifted edge produces no lock and no error.
5. Force 300 errors → `o_err_cnt` saturates at 255.
   - Two violations in one cycle increment the count by 1.
6. Assert `rst_n` at pixel (320,240) → all outputs 0 asynchronously.
   - After release, lock reacquired at the next v sync.

Source files
------------

// File: rtl/vga_sync_rx.sv
// VGA raster receiver: locks onto an active-low h/v sync pair using the
// defs_vga timing constants and rebuilds draw_active and pixel coordinates.

package defs_vga;
  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FRONT  = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BACK   = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FRONT  = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BACK   = 33;
endpackage

module vga_sync_rx
  import defs_vga::*;
#(
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_h_sync,
  input  logic                            i_v_sync,
  output logic                            o_locked,
  output logic                            o_draw_active,
  output logic [$clog2(VGA_H_ACTIVE)-1:0] o_active_x,
  output logic [$clog2(VGA_V_ACTIVE)-1:0] o_active_y,
  output logic                            o_frame_start,
  output logic                            o_err,
  output logic [ERR_CNT_W-1:0]            o_err_cnt
);

  localparam int unsigned H_TOTAL  = VGA_H_ACTIVE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int unsigned V_TOTAL  = VGA_V_ACTIVE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;
  localparam int unsigned HS_START = VGA_H_ACTIVE + VGA_H_FRONT;
  localparam int unsigned HS_END   = HS_START + VGA_H_SYNC;
  localparam int unsigned VS_START = VGA_V_ACTIVE + VGA_V_FRONT;
  localparam int unsigned VS_END   = VS_START + VGA_V_SYNC;

  localparam int unsigned XW  = $clog2(H_TOTAL);
  localparam int unsigned YW  = $clog2(V_TOTAL);
  localparam int unsigned AXW = $clog2(VGA_H_ACTIVE);
  localparam int unsigned AYW = $clog2(VGA_V_ACTIVE);

  localparam logic [XW-1:0] X_HS_START = XW'(HS_START);
  localparam logic [XW-1:0] X_HS_END   = XW'(HS_END);
  localparam logic [XW-1:0] X_LAST     = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] X_ACTIVE   = XW'(VGA_H_ACTIVE);
  localparam logic [YW-1:0] Y_VS_START = YW'(VS_START);
  localparam logic [YW-1:0] Y_VS_END   = YW'(VS_END);
  localparam logic [YW-1:0] Y_LAST     = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] Y_ACTIVE   = YW'(VGA_V_ACTIVE);

  typedef enum logic [1:0] {
    SEARCH,
    H_ALIGNED,
    LOCKED
  } state_t;

  state_t          state_q, state_d;
  logic            h_prev, v_prev;
  logic [XW-1:0]   x_cnt, x_cur, x_nxt;
  logic [YW-1:0]   y_cnt, y_cur, y_nxt;
  logic            h_fall, h_rise, v_fall, v_rise;
  logic            vs_accept, viol, err_d, draw_d, x_wrap;

  // Edge detection, position prediction, violation checks and next state.
  always_comb begin
    h_fall = h_prev & ~i_h_sync;
    h_rise = ~h_prev & i_h_sync;
    v_fall = v_prev & ~i_v_sync;
    v_rise = ~v_prev & i_v_sync;

    // A correct h fall while locked already has x_cnt == HS_START, and an
    // erroring one realigns x, so every h fall can snap x unconditionally.
    x_cur = h_fall ? X_HS_START : x_cnt;

    vs_accept = (state_q == H_ALIGNED) && v_fall && (x_cur == '0);
    y_cur     = vs_accept ? Y_VS_START : y_cnt;

    x_wrap = (x_cur == X_LAST);
    x_nxt  = x_wrap ? '0 : x_cur + XW'(1);
    y_nxt  = y_cur;
    if (x_wrap) y_nxt = (y_cur == Y_LAST) ? '0 : y_cur + YW'(1);

    viol = (h_fall && (x_cnt != X_HS_START))
        || ((x_cnt == X_HS_START) && i_h_sync)
        || (h_rise && (x_cnt != X_HS_END))
        || (v_fall && ((x_cnt != '0) || (y_cnt != Y_VS_START)))
        || (v_rise && ((x_cnt != '0) || (y_cnt != Y_VS_END)));
    err_d = (state_q == LOCKED) && viol;

    state_d = state_q;
    case (state_q)
      SEARCH:    if (h_fall) state_d = H_ALIGNED;
      H_ALIGNED: if (vs_accept) state_d = LOCKED;
      LOCKED:    if (viol) state_d = h_fall ? H_ALIGNED : SEARCH;
      default:   state_d = SEARCH;
    endcase

    draw_d = (state_q == LOCKED) && (x_cur < X_ACTIVE) && (y_cur < Y_ACTIVE);
  end

  // State, sync history and position counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEARCH;
      h_prev  <= 1'b1;
      v_prev  <= 1'b1;
      x_cnt   <= '0;
      y_cnt   <= '0;
    end else begin
      state_q <= state_d;
      h_prev  <= i_h_sync;
      v_prev  <= i_v_sync;
      x_cnt   <= x_nxt;
      y_cnt   <= y_nxt;
    end
  end

  // Registered outputs and saturating error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_locked      <= 1'b0;
      o_draw_active <= 1'b0;
      o_active_x    <= '0;
      o_active_y    <= '0;
      o_frame_start <= 1'b0;
      o_err         <= 1'b0;
      o_err_cnt     <= '0;
    end else begin
      o_locked      <= (state_d == LOCKED);
      o_draw_active <= draw_d;
      o_active_x    <= draw_d ? x_cur[AXW-1:0] : '0;
      o_active_y    <= draw_d ? y_cur[AYW-1:0] : '0;
      o_frame_start <= draw_d && (x_cur == '0) && (y_cur == '0);
      o_err         <= err_d;
      if (err_d && (o_err_cnt != '1)) o_err_cnt <= o_err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_vga_sync_rx.sv
// Directed bench for vga_sync_rx with a behavioural 640x480 sync source.

module tb_vga_sync_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_h_sync, i_v_sync;
  logic       o_locked, o_draw_active, o_frame_start, o_err;
  logic [9:0] o_active_x;
  logic [8:0] o_active_y;
  logic [7:0] o_err_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int gx, gy;
  bit h_force_hi, h_short, v_force_lo;
  bit exp_draw;
  int fs_seen, steps;

  vga_sync_rx #(.ERR_CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_h_sync     (i_h_sync),
    .i_v_sync     (i_v_sync),
    .o_locked     (o_locked),
    .o_draw_active(o_draw_active),
    .o_active_x   (o_active_x),
    .o_active_y   (o_active_y),
    .o_frame_start(o_frame_start),
    .o_err        (o_err),
    .o_err_cnt    (o_err_cnt)
  );

  // Pixel clock.
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Sync levels for the current source position, with fault overrides.
  task automatic drive_gen();
    logic h_low;
    h_low    = h_short ? (gx >= 656 && gx < 751) : (gx >= 656 && gx < 752);
    i_h_sync = h_force_hi ? 1'b1 : ~h_low;
    i_v_sync = v_force_lo ? 1'b0 : ~(gy >= 490 && gy < 492);
  endtask

  task automatic adv();
    gx++;
    if (gx == 800) begin
      gx = 0;
      gy++;
      if (gy == 525) gy = 0;
    end
    drive_gen();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int x, input int y);
    int n;
    n = 0;
    while (!(gx == x && gy == y)) begin
      if (n >= 30000) begin
        n_cmp++;
        n_bad++;
        $display("FAIL run_to_timeout: got (%0d,%0d) expected (%0d,%0d)", gx, gy, x, y);
        break;
      end
      tick();
      adv();
      n++;
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    gx = 0; gy = 0;
    h_force_hi = 0; h_short = 0; v_force_lo = 0;
    i_h_sync = 1'b1; i_v_sync = 1'b1;
    #12;
    check_eq("rst_locked", 32'(o_locked), 0);
    check_eq("rst_draw", 32'(o_draw_active), 0);
    check_eq("rst_x", 32'(o_active_x), 0);
    check_eq("rst_y", 32'(o_active_y), 0);
    check_eq("rst_fs", 32'(o_frame_start), 0);
    check_eq("rst_err", 32'(o_err), 0);
    check_eq("rst_errcnt", 32'(o_err_cnt), 0);
    tick();
    gx = 0; gy = 489; drive_gen();
    rst_n = 1'b1;

    // 1: acquire lock from line 489, then track into the next frame.
    run_to(799, 489);
    tick(); check_eq("t1_prelock", 32'(o_locked), 0); adv();
    tick(); check_eq("t1_lock", 32'(o_locked), 1); check_eq("t1_lock_err", 32'(o_err), 0); adv();
    fs_seen = 0;
    steps = 0;
    while (!(gx == 320 && gy == 1) && steps < 40000) begin
      tick();
      exp_draw = (gx < 640) && (gy < 480);
      check_eq("t1_locked", 32'(o_locked), 1);
      check_eq("t1_err", 32'(o_err), 0);
      check_eq("t1_draw", 32'(o_draw_active), 32'(exp_draw));
      check_eq("t1_x", 32'(o_active_x), exp_draw ? gx : 0);
      check_eq("t1_y", 32'(o_active_y), exp_draw ? gy : 0);
      check_eq("t1_fs", 32'(o_frame_start), 32'(gx == 0 && gy == 0));
      if (o_frame_start) fs_seen++;
      adv();
      steps++;
    end
    check_eq("t1_reached", 32'(gx == 320 && gy == 1), 1);
    check_eq("t1_fs_once", fs_seen, 1);
    check_eq("t1_errcnt", 32'(o_err_cnt), 0);

    // 6: asynchronous reset mid active area, then reacquire.
    tick();
    check_eq("t6_pre_draw", 32'(o_draw_active), 1);
    check_eq("t6_pre_x", 32'(o_active_x), 320);
    check_eq("t6_pre_y", 32'(o_active_y), 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_locked", 32'(o_locked), 0);
    check_eq("t6_draw", 32'(o_draw_active), 0);
    check_eq("t6_x", 32'(o_active_x), 0);
    check_eq("t6_y", 32'(o_active_y), 0);
    check_eq("t6_fs", 32'(o_frame_start), 0);
    check_eq("t6_err", 32'(o_err), 0);
    check_eq("t6_errcnt", 32'(o_err_cnt), 0);
    repeat (3) tick();
    gx = 0; gy = 489; drive_gen();
    rst_n = 1'b1;
    run_to(0, 490);
    tick(); check_eq("t6_relock", 32'(o_locked), 1); adv();

    // 2: missing h sync for one line.
    run_to(0, 491);
    h_force_hi = 1; drive_gen();
    run_to(655, 491);
    tick(); check_eq("t2_pre_err", 32'(o_err), 0); check_eq("t2_pre_locked", 32'(o_locked), 1); adv();
    tick();
    check_eq("t2_err", 32'(o_err), 1);
    check_eq("t2_locked", 32'(o_locked), 0);
    check_eq("t2_errcnt", 32'(o_err_cnt), 1);
    adv();
    tick(); check_eq("t2_err_once", 32'(o_err), 0); adv();
    run_to(0, 492);
    h_force_hi = 0; drive_gen();
    run_to(0, 493);
    gy = 490; drive_gen();
    tick(); check_eq("t2_relock", 32'(o_locked), 1); adv();

    // 3: 95-cycle h sync pulse, rising edge at x=751.
    run_to(0, 491);
    h_short = 1; drive_gen();
    run_to(750, 491);
    tick(); check_eq("t3_pre_err", 32'(o_err), 0); check_eq("t3_pre_locked", 32'(o_locked), 1); adv();
    tick();
    check_eq("t3_err", 32'(o_err), 1);
    check_eq("t3_locked", 32'(o_locked), 0);
    check_eq("t3_errcnt", 32'(o_err_cnt), 2);
    adv();
    run_to(0, 492);
    h_short = 0; drive_gen();
    run_to(0, 493);
    gy = 490; drive_gen();
    tick(); check_eq("t3_relock", 32'(o_locked), 1); adv();

    // 4: v falling edge at x=5, first while locked, then while h-aligned.
    run_to(5, 493);
    v_force_lo = 1; drive_gen();
    tick();
    check_eq("t4_err", 32'(o_err), 1);
    check_eq("t4_locked", 32'(o_locked), 0);
    check_eq("t4_errcnt", 32'(o_err_cnt), 3);
    adv();
    run_to(100, 493);
    v_force_lo = 0; drive_gen();
    run_to(5, 494);
    v_force_lo = 1; drive_gen();
    tick();
    check_eq("t4_al_err", 32'(o_err), 0);
    check_eq("t4_al_locked", 32'(o_locked), 0);
    adv();
    run_to(0, 495);
    tick();
    check_eq("t4_al_nolock", 32'(o_locked), 0);
    check_eq("t4_al_errcnt", 32'(o_err_cnt), 3);
    adv();
    run_to(10, 495);
    v_force_lo = 0; drive_gen();
    run_to(0, 496);
    gy = 490; drive_gen();
    tick(); check_eq("t4_relock", 32'(o_locked), 1); adv();

    // 5: repeated lock/error cycles, each error carrying two violations.
    for (int i = 0; i < 260; i++) begin
      i_h_sync = 1'b0; i_v_sync = 1'b1;
      tick();
      if (i == 0) begin
        check_eq("t5_err", 32'(o_err), 1);
        check_eq("t5_dual_once", 32'(o_err_cnt), 4);
        check_eq("t5_locked", 32'(o_locked), 0);
      end
      if (i == 250) check_eq("t5_cnt_254", 32'(o_err_cnt), 254);
      if (i == 251) check_eq("t5_cnt_255", 32'(o_err_cnt), 255);
      i_h_sync = 1'b1;
      repeat (143) tick();
      i_v_sync = 1'b0;
      tick();
      if (i == 0) check_eq("t5_relock", 32'(o_locked), 1);
    end
    i_h_sync = 1'b0; i_v_sync = 1'b1;
    tick();
    check_eq("t5_err_sat", 32'(o_err), 1);
    check_eq("t5_saturated", 32'(o_err_cnt), 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
